// File: rtl/shift_register.sv
// n-bit parallel-load shift register. Load has priority over shift.
// Shifting moves data toward the MSB, and sdatain enters at bit 0.
module shift_register #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [n-1:0] pdatain,
  input  logic         sdatain,
  input  logic         load,
  input  logic         shift,
  output logic [n-1:0] pdataout
);

  if (n < 2) begin : g_bad_width
    $error("shift_register: n must be >= 2");
  end

  logic [n-1:0] r_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)   r_data <= '0;
    else if (load)  r_data <= pdatain;
    else if (shift) r_data <= {r_data[n-2:0], sdatain};
  end

  assign pdataout = r_data;

`ifndef SYNTHESIS
  a_load: assert property (@(posedge clk) disable iff (!n_reset)
    load |=> pdataout == $past(pdatain));

  a_shift: assert property (@(posedge clk) disable iff (!n_reset)
    (!load && shift) |=> pdataout == {$past(pdataout[n-2:0]), $past(sdatain)});

  a_hold: assert property (@(posedge clk) disable iff (!n_reset)
    (!load && !shift) |=> $stable(pdataout));

  a_reset: assert property (@(posedge clk) !n_reset |-> pdataout == '0);
`endif

endmodule

// File: tb/tb_shift_register.sv
// Directed and random test of shift_register.
// The bench compares the DUT against a simple arithmetic model.
module tb_shift_register;

  localparam int N = 8;

  logic         clk;
  logic         n_reset;
  logic [N-1:0] pdatain;
  logic         sdatain;
  logic         load;
  logic         shift;
  logic [N-1:0] pdataout;

  int errors = 0;
  int checks = 0;
  int model;

  shift_register #(.n(N)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .pdatain  (pdatain),
    .sdatain  (sdatain),
    .load     (load),
    .shift    (shift),
    .pdataout (pdataout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Drive the inputs on the falling edge, clock once, and sample 1 ns after the rising edge.
  task automatic step(input logic ld, input logic sh, input logic [N-1:0] pd, input logic sd);
    @(negedge clk);
    load = ld; shift = sh; pdatain = pd; sdatain = sd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_reset = 1'b0; load = 1'b0; shift = 1'b0; pdatain = '0; sdatain = 1'b0;
    #2;
    check("reset_no_edge", pdataout, 8'h00);

    @(negedge clk);
    n_reset = 1'b1;
    step(0, 0, 8'h5A, 1);                 check("idle_after_reset", pdataout, 8'h00);

    step(1, 0, 8'hCC, 0);                 check("load_cc", pdataout, 8'hCC);
    step(0, 0, 8'h00, 1);                 check("hold_cc", pdataout, 8'hCC);

    step(0, 1, 8'h00, 0);                 check("shift0_1", pdataout, 8'h98);
    step(0, 1, 8'h00, 0);                 check("shift0_2", pdataout, 8'h30);

    step(1, 0, 8'hCC, 0);                 check("reload_cc", pdataout, 8'hCC);
    step(0, 1, 8'h00, 1);                 check("shift1_1", pdataout, 8'h99);
    step(0, 1, 8'h00, 1);                 check("shift1_2", pdataout, 8'h33);
    step(0, 1, 8'h00, 1);                 check("shift1_3", pdataout, 8'h67);
    step(0, 1, 8'h00, 1);                 check("shift1_4", pdataout, 8'hCF);

    // Pulse reset between clock edges while a shift is still enabled.
    @(negedge clk);
    n_reset = 1'b0;
    #1;
    check("async_reset_mid_shift", pdataout, 8'h00);
    load = 1'b1; pdatain = 8'hFF;
    @(posedge clk); #1;
    check("load_ignored_in_reset", pdataout, 8'h00);
    @(negedge clk);
    n_reset = 1'b1;

    step(1, 1, 8'hCC, 1);                 check("collision_load_wins", pdataout, 8'hCC);
    step(0, 1, 8'h00, 1);                 check("shift_after_release", pdataout, 8'h99);

    // The model applies the priority order reset, then load, then shift.
    model = 'h99;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n_reset = ($urandom_range(0, 31) != 0);
      load    = ($urandom_range(0, 3) == 0);
      shift   = $urandom_range(0, 1) == 1;
      pdatain = N'($urandom);
      sdatain = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
      if (!n_reset)   model = 0;
      else if (load)  model = int'(pdatain);
      else if (shift) model = (model * 2 + int'(sdatain)) % (1 << N);
      check("random", pdataout, N'(model));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
